// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry, the
// hardwired-zero index and the read-source selection used by every read port.
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_ZERO_REG   = 31;
    localparam int NUM_READ_PORTS     = 2;

    typedef enum logic [1:0] {
        SRC_ARRAY = 2'd0,
        SRC_PORT0 = 2'd1,
        SRC_PORT1 = 2'd2
    } readSrc_e;

    // Port 1 is the younger write-back, so it shadows port 0 when both match.
    function automatic readSrc_e selectReadSrc(
        input logic bypassEn,
        input logic hit0,
        input logic hit1
    );
        readSrc_e src;
        src = SRC_ARRAY;
        if (bypassEn && hit1) begin
            src = SRC_PORT1;
        end else if (bypassEn && hit0) begin
            src = SRC_PORT0;
        end
        return src;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: issue sets a destination pending, write-back
// clears it, and a WAW issue to a still-pending register raises a hazard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ZERO_REG   = DEFAULT_ZERO_REG
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         clrEn0,
    input  logic [ADDR_WIDTH-1:0]        clrIdx0,
    input  logic                         clrEn1,
    input  logic [ADDR_WIDTH-1:0]        clrIdx1,
    input  logic                         setEn,
    input  logic [ADDR_WIDTH-1:0]        setIdx,
    output logic [(1<<ADDR_WIDTH)-1:0]   busy,
    output logic                         issueHazard
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [DEPTH-1:0] busyReg;
    logic [DEPTH-1:0] busyNext;
    logic             clrHitsIssue;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gBusy
            localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(gi);
            if (IDX == ZERO_IDX) begin : gZero
                assign busyNext[gi] = 1'b0;
            end else begin : gTrack
                logic setHit;
                logic clrHit;
                assign setHit = setEn && (setIdx == IDX);
                assign clrHit = (clrEn0 && (clrIdx0 == IDX)) || (clrEn1 && (clrIdx1 == IDX));
                // A new producer supersedes a write-back landing in the same cycle.
                assign busyNext[gi] = setHit || (busyReg[gi] && !clrHit);
            end
        end
    endgenerate

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busyReg <= '0;
        end else begin
            busyReg <= busyNext;
        end
    end

    assign clrHitsIssue = (clrEn0 && (clrIdx0 == setIdx)) || (clrEn1 && (clrIdx1 == setIdx));
    assign issueHazard  = setEn && (setIdx != ZERO_IDX) && busyReg[setIdx] && !clrHitsIssue;
    assign busy         = busyReg;

endmodule

// File: rtl/regfile_mp_sb.sv
// Two-read / two-write register file for the pipelined datapath, with optional
// write-to-read bypass and operand-readiness reporting from a busy scoreboard.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int ZERO_REG   = DEFAULT_ZERO_REG,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [ADDR_WIDTH-1:0] RA,
    input  logic [ADDR_WIDTH-1:0] RB,
    output logic [DATA_WIDTH-1:0] BusA,
    output logic [DATA_WIDTH-1:0] BusB,
    output logic                  AReady,
    output logic                  BReady,
    input  logic [ADDR_WIDTH-1:0] RW0,
    input  logic [DATA_WIDTH-1:0] BusW0,
    input  logic                  RegWr0,
    input  logic [ADDR_WIDTH-1:0] RW1,
    input  logic [DATA_WIDTH-1:0] BusW1,
    input  logic                  RegWr1,
    input  logic                  IssueWr,
    input  logic [ADDR_WIDTH-1:0] IssueRd,
    output logic                  IssueHazard
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regArray [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic                  wrEn0;
    logic                  wrEn1;

    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rdData;
    logic [NUM_READ_PORTS-1:0]                 rdReady;

    assign wrEn0 = RegWr0 && (RW0 != ZERO_IDX);
    assign wrEn1 = RegWr1 && (RW1 != ZERO_IDX);

    // Port 1 is written last so it wins a same-index collision.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regArray[i] <= '0;
            end
        end else begin
            if (wrEn0) begin
                regArray[RW0] <= BusW0;
            end
            if (wrEn1) begin
                regArray[RW1] <= BusW1;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) uScoreboard (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .clrEn0      (RegWr0),
        .clrIdx0     (RW0),
        .clrEn1      (RegWr1),
        .clrIdx1     (RW1),
        .setEn       (IssueWr),
        .setIdx      (IssueRd),
        .busy        (busy),
        .issueHazard (IssueHazard)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ_PORTS; gi++) begin : gRead
            logic [ADDR_WIDTH-1:0] addr;
            logic                  isZero;
            logic                  hit0;
            logic                  hit1;
            readSrc_e              src;
            logic [DATA_WIDTH-1:0] data;

            assign addr   = (gi == 0) ? RA : RB;
            assign isZero = (addr == ZERO_IDX);
            assign hit0   = RegWr0 && (RW0 == addr);
            assign hit1   = RegWr1 && (RW1 == addr);
            assign src    = selectReadSrc(BYPASS, hit0, hit1);

            always_comb begin
                data = regArray[addr];
                case (src)
                    SRC_PORT1: data = BusW1;
                    SRC_PORT0: data = BusW0;
                    default:   data = regArray[addr];
                endcase
                if (isZero) begin
                    data = '0;
                end
            end

            // A forwarded value is as good as a committed one for the hazard unit.
            assign rdData[gi]  = data;
            assign rdReady[gi] = isZero || !busy[addr] || (src != SRC_ARRAY);
        end
    endgenerate

    assign BusA   = rdData[0];
    assign BusB   = rdData[1];
    assign AReady = rdReady[0];
    assign BReady = rdReady[1];

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench: stimulus pushes expected read-port/hazard values, a
// negedge monitor pops and compares them against three configured instances.
module tb_regfile_mp_sb;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        ar;
        logic        br;
        logic        hz;
    } obs_t;

    typedef struct {
        string name;
        obs_t  e1;
        obs_t  e0;
        obs_t  es;
        bit    chkS;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [4:0]  RA, RB, RW0, RW1, IssueRd;
    logic [63:0] BusW0, BusW1;
    logic        RegWr0, RegWr1, IssueWr;

    logic [63:0] busA1, busB1, busA0, busB0;
    logic        aRdy1, bRdy1, hz1, aRdy0, bRdy0, hz0;
    logic [31:0] busAS, busBS;
    logic        aRdyS, bRdyS, hzS;

    int   checks = 0;
    int   errors = 0;
    int   txnCount = 0;
    exp_t expQ[$];
    exp_t cur;

    logic [63:0] mReg [32];
    logic        mBusy [32];
    logic [31:0] sReg [16];
    logic        sBusy [16];

    always #5 Clk = ~Clk;

    regfile_mp_sb #(.BYPASS(1'b1)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .RA(RA), .RB(RB), .BusA(busA1), .BusB(busB1),
        .AReady(aRdy1), .BReady(bRdy1), .RW0(RW0), .BusW0(BusW0), .RegWr0(RegWr0),
        .RW1(RW1), .BusW1(BusW1), .RegWr1(RegWr1), .IssueWr(IssueWr), .IssueRd(IssueRd),
        .IssueHazard(hz1)
    );

    regfile_mp_sb #(.BYPASS(1'b0)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .RA(RA), .RB(RB), .BusA(busA0), .BusB(busB0),
        .AReady(aRdy0), .BReady(bRdy0), .RW0(RW0), .BusW0(BusW0), .RegWr0(RegWr0),
        .RW1(RW1), .BusW1(BusW1), .RegWr1(RegWr1), .IssueWr(IssueWr), .IssueRd(IssueRd),
        .IssueHazard(hz0)
    );

    regfile_mp_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(15), .BYPASS(1'b1)) dutS (
        .Clk(Clk), .Reset_n(Reset_n), .RA(RA[3:0]), .RB(RB[3:0]), .BusA(busAS), .BusB(busBS),
        .AReady(aRdyS), .BReady(bRdyS), .RW0(RW0[3:0]), .BusW0(BusW0[31:0]), .RegWr0(RegWr0),
        .RW1(RW1[3:0]), .BusW1(BusW1[31:0]), .RegWr1(RegWr1), .IssueWr(IssueWr),
        .IssueRd(IssueRd[3:0]), .IssueHazard(hzS)
    );

    function automatic obs_t mk(input logic [63:0] a, input logic [63:0] b,
                                input logic ar, input logic br, input logic hz);
        obs_t o;
        o.a = a; o.b = b; o.ar = ar; o.br = br; o.hz = hz;
        return o;
    endfunction

    task automatic cmpField(input string name, input string tag, input string field,
                            input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%s] %s: got %h expected %h", name, tag, field, act, exp);
        end
    endtask

    task automatic cmpObs(input string name, input string tag, input obs_t act, input obs_t exp);
        cmpField(name, tag, "BusA", act.a, exp.a);
        cmpField(name, tag, "BusB", act.b, exp.b);
        cmpField(name, tag, "AReady", {63'b0, act.ar}, {63'b0, exp.ar});
        cmpField(name, tag, "BReady", {63'b0, act.br}, {63'b0, exp.br});
        cmpField(name, tag, "IssueHazard", {63'b0, act.hz}, {63'b0, exp.hz});
    endtask

    // Monitor: sample mid-cycle, away from the rising edge.
    always @(negedge Clk) begin
        if (expQ.size() > 0) begin
            cur = expQ.pop_front();
            txnCount++;
            cmpObs(cur.name, "byp1", mk(busA1, busB1, aRdy1, bRdy1, hz1), cur.e1);
            cmpObs(cur.name, "byp0", mk(busA0, busB0, aRdy0, bRdy0, hz0), cur.e0);
            if (cur.chkS) begin
                cmpObs(cur.name, "w32a4", mk({32'b0, busAS}, {32'b0, busBS}, aRdyS, bRdyS, hzS), cur.es);
            end
            $display("txn %0d %s busA=%h busB=%h aReady=%b bReady=%b hazard=%b",
                     txnCount, cur.name, busA1, busB1, aRdy1, bRdy1, hz1);
        end
    end

    task automatic nextCycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        RegWr0 = 1'b0; RegWr1 = 1'b0; IssueWr = 1'b0;
    endtask

    task automatic push(input string name, input obs_t e1, input obs_t e0);
        exp_t e;
        e.name = name; e.e1 = e1; e.e0 = e0;
        e.es = mk(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        e.chkS = 1'b0;
        expQ.push_back(e);
    endtask

    task automatic pushBoth(input string name, input obs_t e);
        push(name, e, e);
    endtask

    function automatic void readModel(input bit byp, input logic [63:0] stored, input logic busyBit,
                                      input bit isZero, input bit hit0, input bit hit1,
                                      input logic [63:0] d0, input logic [63:0] d1,
                                      output logic [63:0] val, output logic rdy);
        val = stored;
        rdy = !busyBit;
        if (isZero) begin
            val = 64'd0; rdy = 1'b1;
        end else if (byp && hit1) begin
            val = d1; rdy = 1'b1;
        end else if (byp && hit0) begin
            val = d0; rdy = 1'b1;
        end
    endfunction

    function automatic obs_t predBig(input bit byp);
        obs_t o;
        readModel(byp, mReg[RA], mBusy[RA], RA == 5'd31, RegWr0 && RW0 == RA, RegWr1 && RW1 == RA,
                  BusW0, BusW1, o.a, o.ar);
        readModel(byp, mReg[RB], mBusy[RB], RB == 5'd31, RegWr0 && RW0 == RB, RegWr1 && RW1 == RB,
                  BusW0, BusW1, o.b, o.br);
        o.hz = IssueWr && (IssueRd != 5'd31) && mBusy[IssueRd] &&
               !((RegWr0 && RW0 == IssueRd) || (RegWr1 && RW1 == IssueRd));
        return o;
    endfunction

    function automatic obs_t predSmall();
        obs_t o;
        logic [3:0] a, b, w0, w1, ir;
        a = RA[3:0]; b = RB[3:0]; w0 = RW0[3:0]; w1 = RW1[3:0]; ir = IssueRd[3:0];
        readModel(1'b1, {32'b0, sReg[a]}, sBusy[a], a == 4'd15, RegWr0 && w0 == a, RegWr1 && w1 == a,
                  {32'b0, BusW0[31:0]}, {32'b0, BusW1[31:0]}, o.a, o.ar);
        readModel(1'b1, {32'b0, sReg[b]}, sBusy[b], b == 4'd15, RegWr0 && w0 == b, RegWr1 && w1 == b,
                  {32'b0, BusW0[31:0]}, {32'b0, BusW1[31:0]}, o.b, o.br);
        o.hz = IssueWr && (ir != 4'd15) && sBusy[ir] &&
               !((RegWr0 && w0 == ir) || (RegWr1 && w1 == ir));
        return o;
    endfunction

    task automatic updateModels();
        if (RegWr0 && RW0 != 5'd31) mReg[RW0] = BusW0;
        if (RegWr1 && RW1 != 5'd31) mReg[RW1] = BusW1;
        if (RegWr0) mBusy[RW0] = 1'b0;
        if (RegWr1) mBusy[RW1] = 1'b0;
        if (IssueWr && IssueRd != 5'd31) mBusy[IssueRd] = 1'b1;
        if (RegWr0 && RW0[3:0] != 4'd15) sReg[RW0[3:0]] = BusW0[31:0];
        if (RegWr1 && RW1[3:0] != 4'd15) sReg[RW1[3:0]] = BusW1[31:0];
        if (RegWr0) sBusy[RW0[3:0]] = 1'b0;
        if (RegWr1) sBusy[RW1[3:0]] = 1'b0;
        if (IssueWr && IssueRd[3:0] != 4'd15) sBusy[IssueRd[3:0]] = 1'b1;
    endtask

    function automatic logic [4:0] pickAddr();
        logic [4:0] r;
        r = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 5))
            0: r = 5'd7;
            1: r = 5'd9;
            2: r = 5'd31;
            3: r = 5'd15;
            default: r = 5'($urandom_range(0, 31));
        endcase
        return r;
    endfunction

    initial begin
        exp_t e;
        RA = '0; RB = 5'd1; RW0 = '0; RW1 = '0; IssueRd = '0;
        BusW0 = '0; BusW1 = '0; RegWr0 = 1'b0; RegWr1 = 1'b0; IssueWr = 1'b0;
        #12 Reset_n = 1'b1;

        // Directed vectors: {BusA, BusB, AReady, BReady, IssueHazard}
        nextCycle(); idle(); RA = 5'd0; RB = 5'd1;
        pushBoth("reset_state", mk(64'd0, 64'd0, 1, 1, 0));

        nextCycle(); idle(); RegWr0 = 1; RW0 = 5'd4; BusW0 = 64'hDEAD_BEEF; RA = 5'd4; RB = 5'd5;
        push("wr_same_cycle", mk(64'hDEAD_BEEF, 64'd0, 1, 1, 0), mk(64'd0, 64'd0, 1, 1, 0));

        nextCycle(); idle(); RA = 5'd4; RB = 5'd4;
        pushBoth("wr_next_cycle", mk(64'hDEAD_BEEF, 64'hDEAD_BEEF, 1, 1, 0));

        nextCycle(); idle(); RegWr0 = 1; RW0 = 5'd7; BusW0 = 64'd1;
        RegWr1 = 1; RW1 = 5'd7; BusW1 = 64'd2; RA = 5'd7; RB = 5'd7;
        push("dual_wr_bypass", mk(64'd2, 64'd2, 1, 1, 0), mk(64'd0, 64'd0, 1, 1, 0));

        nextCycle(); idle(); RA = 5'd7; RB = 5'd4;
        pushBoth("dual_wr_stored", mk(64'd2, 64'hDEAD_BEEF, 1, 1, 0));

        nextCycle(); idle(); RegWr1 = 1; RW1 = 5'd31; BusW1 = 64'hFF; RA = 5'd31; RB = 5'd31;
        pushBoth("zero_wr_bypass", mk(64'd0, 64'd0, 1, 1, 0));

        nextCycle(); idle(); IssueWr = 1; IssueRd = 5'd31; RA = 5'd31; RB = 5'd7;
        pushBoth("zero_issue", mk(64'd0, 64'd2, 1, 1, 0));

        nextCycle(); idle(); IssueWr = 1; IssueRd = 5'd31; RA = 5'd31; RB = 5'd31;
        pushBoth("zero_reissue", mk(64'd0, 64'd0, 1, 1, 0));

        nextCycle(); idle(); IssueWr = 1; IssueRd = 5'd9; RA = 5'd9; RB = 5'd4;
        pushBoth("issue_r9", mk(64'd0, 64'hDEAD_BEEF, 1, 1, 0));

        nextCycle(); idle(); IssueWr = 1; IssueRd = 5'd9; RA = 5'd9; RB = 5'd9;
        pushBoth("waw_r9", mk(64'd0, 64'd0, 0, 0, 1));

        nextCycle(); idle(); RA = 5'd9; RB = 5'd7;
        pushBoth("busy_r9", mk(64'd0, 64'd2, 0, 1, 0));

        nextCycle(); idle(); RegWr0 = 1; RW0 = 5'd9; BusW0 = 64'h99; RA = 5'd9; RB = 5'd9;
        push("wb_r9", mk(64'h99, 64'h99, 1, 1, 0), mk(64'd0, 64'd0, 0, 0, 0));

        nextCycle(); idle(); RA = 5'd9; RB = 5'd9;
        pushBoth("cleared_r9", mk(64'h99, 64'h99, 1, 1, 0));

        nextCycle(); idle(); IssueWr = 1; IssueRd = 5'd9; RA = 5'd9; RB = 5'd9;
        pushBoth("reissue_r9", mk(64'h99, 64'h99, 1, 1, 0));

        nextCycle(); idle(); IssueWr = 1; IssueRd = 5'd9; RegWr0 = 1; RW0 = 5'd9; BusW0 = 64'h77;
        RA = 5'd9; RB = 5'd9;
        push("set_clr_r9", mk(64'h77, 64'h77, 1, 1, 0), mk(64'h99, 64'h99, 0, 0, 0));

        nextCycle(); idle(); RA = 5'd9; RB = 5'd9;
        pushBoth("set_wins_r9", mk(64'h77, 64'h77, 0, 0, 0));

        nextCycle(); idle(); RegWr1 = 1; RW1 = 5'd9; BusW1 = 64'h55; RA = 5'd9; RB = 5'd4;
        push("wb_p1_r9", mk(64'h55, 64'hDEAD_BEEF, 1, 1, 0), mk(64'h77, 64'hDEAD_BEEF, 0, 1, 0));

        nextCycle(); idle(); RA = 5'd9; RB = 5'd9;
        pushBoth("cleared2_r9", mk(64'h55, 64'h55, 1, 1, 0));

        nextCycle(); idle(); RegWr0 = 1; RW0 = 5'd3; BusW0 = 64'd5; IssueWr = 1; IssueRd = 5'd3;
        RA = 5'd3; RB = 5'd9;
        push("wr_issue_r3", mk(64'd5, 64'h55, 1, 1, 0), mk(64'd0, 64'h55, 1, 1, 0));

        nextCycle(); idle(); RA = 5'd3; RB = 5'd9;
        pushBoth("busy_r3", mk(64'd5, 64'h55, 0, 1, 0));

        // Asynchronous reset mid-cycle with a write pending on another index.
        nextCycle(); idle(); RegWr1 = 1; RW1 = 5'd5; BusW1 = 64'h1234; RA = 5'd3; RB = 5'd9;
        Reset_n = 1'b0;
        pushBoth("async_reset", mk(64'd0, 64'd0, 1, 1, 0));
        @(negedge Clk); #2;
        idle(); Reset_n = 1'b1;

        nextCycle(); idle(); RA = 5'd5; RB = 5'd3;
        pushBoth("post_reset", mk(64'd0, 64'd0, 1, 1, 0));

        // Random regression against the reference models.
        for (int i = 0; i < 32; i++) begin mReg[i] = '0; mBusy[i] = 1'b0; end
        for (int i = 0; i < 16; i++) begin sReg[i] = '0; sBusy[i] = 1'b0; end
        for (int n = 0; n < 2000; n++) begin
            nextCycle();
            RegWr0 = 1'($urandom_range(0, 1)); RW0 = pickAddr(); BusW0 = {$urandom, $urandom};
            RegWr1 = 1'($urandom_range(0, 1)); RW1 = pickAddr(); BusW1 = {$urandom, $urandom};
            IssueWr = ($urandom_range(0, 2) == 0); IssueRd = pickAddr();
            RA = pickAddr(); RB = pickAddr();
            e.name = "rnd"; e.e1 = predBig(1'b1); e.e0 = predBig(1'b0); e.es = predSmall(); e.chkS = 1'b1;
            expQ.push_back(e);
            updateModels();
        end

        nextCycle(); idle();
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge Clk);
        if (expQ.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d expected transactions left unchecked, required 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
